// File: rtl/fifo_wptr_full.sv
// fifo_wptr_full: write-domain pointer and flag stage of an asynchronous FIFO.
// Owns the write binary pointer (memory address) and the registered Gray pointer
// exported to the read domain, synchronizes the read Gray pointer into W_CLK and
// derives FULL, a conservative fill level and a sticky overflow flag.
// Optional feature macro: FIFO_ALMOST_FULL_EN adds the ALMOST_FULL output.
module fifo_wptr_full #(
    parameter int PTR_WIDTH   = 3,
    parameter int SYNC_STAGES = 2,
    parameter int AF_LEVEL    = 6
) (
    input  logic                 W_CLK,
    input  logic                 W_RST,
    input  logic                 W_EN,
    input  logic [PTR_WIDTH:0]   R_GPTR_ASYNC,
    output logic [PTR_WIDTH-1:0] B_WPTR,
    output logic [PTR_WIDTH:0]   G_WPTR,
    output logic                 FULL,
    output logic                 W_ACCEPT,
    output logic [PTR_WIDTH:0]   W_LEVEL,
`ifdef FIFO_ALMOST_FULL_EN
    output logic                 OVERFLOW,
    output logic                 ALMOST_FULL
`else
    output logic                 OVERFLOW
`endif
);

    // Elaboration-time parameter sanity
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("fifo_wptr_full: SYNC_STAGES must be >= 2");
    end
    if (PTR_WIDTH < 1) begin : g_bad_ptr
        $error("fifo_wptr_full: PTR_WIDTH must be >= 1");
    end
    if (AF_LEVEL < 0) begin : g_bad_af_neg
        $error("fifo_wptr_full: AF_LEVEL must not be negative");
    end

    function automatic logic [PTR_WIDTH:0] f_gray2bin(input logic [PTR_WIDTH:0] g);
        logic [PTR_WIDTH:0] b;
        b[PTR_WIDTH] = g[PTR_WIDTH];
        for (int i = PTR_WIDTH - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [PTR_WIDTH:0] f_bin2gray(input logic [PTR_WIDTH:0] b);
        return b ^ (b >> 1);
    endfunction

    // Full pattern: the read pointer with its two MSBs flipped is exactly one lap behind.
    localparam logic [PTR_WIDTH:0] FULL_FLIP = {2'b11, {(PTR_WIDTH-1){1'b0}}};

    logic [PTR_WIDTH:0] r_wbin;
    logic [PTR_WIDTH:0] r_gptr;
    logic [PTR_WIDTH:0] r_rq [SYNC_STAGES];
    logic               r_full;
    logic               r_overflow;

    logic               w_accept;
    logic [PTR_WIDTH:0] w_wbin_next;
    logic [PTR_WIDTH:0] w_wgray_next;
    logic [PTR_WIDTH:0] w_rgs;
    logic [PTR_WIDTH:0] w_rbin_s;
    logic [PTR_WIDTH:0] w_level;

    // Accept decision, next pointer values and fill level from registered state
    always_comb begin
        w_accept     = W_EN && !r_full && !W_RST;
        w_wbin_next  = r_wbin + (PTR_WIDTH+1)'(w_accept);
        w_wgray_next = f_bin2gray(w_wbin_next);
        w_rgs        = r_rq[SYNC_STAGES-1];
        w_rbin_s     = f_gray2bin(w_rgs);
        w_level      = r_wbin - w_rbin_s;
    end

    // Read Gray pointer synchronizer; the only logic that touches R_GPTR_ASYNC
    always_ff @(posedge W_CLK or posedge W_RST) begin
        if (W_RST) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_rq[i] <= '0;
            end
        end else begin
            r_rq[0] <= R_GPTR_ASYNC;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_rq[i] <= r_rq[i-1];
            end
        end
    end

    // Write pointers, registered FULL and sticky overflow
    always_ff @(posedge W_CLK or posedge W_RST) begin
        if (W_RST) begin
            r_wbin     <= '0;
            r_gptr     <= '0;
            r_full     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_wbin <= w_wbin_next;
            r_gptr <= w_wgray_next;
            r_full <= (w_wgray_next == (w_rgs ^ FULL_FLIP));
            if (W_EN && r_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign B_WPTR   = r_wbin[PTR_WIDTH-1:0];
    assign G_WPTR   = r_gptr;
    assign FULL     = r_full;
    assign W_ACCEPT = w_accept;
    assign W_LEVEL  = w_level;
    assign OVERFLOW = r_overflow;

`ifdef FIFO_ALMOST_FULL_EN
    if (AF_LEVEL > 2**PTR_WIDTH) begin : g_bad_af
        $error("fifo_wptr_full: AF_LEVEL exceeds FIFO depth");
    end

    // Almost-full threshold on the conservative fill level
    always_comb begin
        ALMOST_FULL = !W_RST && (w_level >= (PTR_WIDTH+1)'(AF_LEVEL));
    end
`endif

endmodule

// File: tb/tb_fifo_wptr_full.sv
// tb_fifo_wptr_full: randomized and directed bench for fifo_wptr_full
// (PTR_WIDTH=3, SYNC_STAGES=2) against a count-based reference model.
module tb_fifo_wptr_full;

    localparam int PW  = 3;
    localparam int SS  = 2;
    localparam int AFL = 6;

    logic          W_CLK;
    logic          W_RST;
    logic          W_EN;
    logic [PW:0]   R_GPTR_ASYNC;
    logic [PW-1:0] B_WPTR;
    logic [PW:0]   G_WPTR;
    logic          FULL;
    logic          W_ACCEPT;
    logic [PW:0]   W_LEVEL;
    logic          OVERFLOW;
`ifdef FIFO_ALMOST_FULL_EN
    logic          ALMOST_FULL;
`endif

    fifo_wptr_full #(.PTR_WIDTH(PW), .SYNC_STAGES(SS), .AF_LEVEL(AFL)) dut (
        .W_CLK        (W_CLK),
        .W_RST        (W_RST),
        .W_EN         (W_EN),
        .R_GPTR_ASYNC (R_GPTR_ASYNC),
        .B_WPTR       (B_WPTR),
        .G_WPTR       (G_WPTR),
        .FULL         (FULL),
        .W_ACCEPT     (W_ACCEPT),
        .W_LEVEL      (W_LEVEL),
`ifdef FIFO_ALMOST_FULL_EN
        .OVERFLOW     (OVERFLOW),
        .ALMOST_FULL  (ALMOST_FULL)
`else
        .OVERFLOW     (OVERFLOW)
`endif
    );

    initial W_CLK = 1'b0;
    always #5 W_CLK = ~W_CLK;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: total accepted writes, read-pointer history as seen at each edge
    int       m_wcnt;
    int       m_rcnt;
    logic     m_full;
    logic     m_ovf;
    int       m_hist [SS];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    function automatic int gray(input int b);
        return (b ^ (b >> 1)) & 15;
    endfunction

    // Gray to binary by search over all codes
    function automatic int ungray(input int g);
        for (int b = 0; b < 16; b++) if (gray(b) == g) return b;
        return 0;
    endfunction

    function automatic int m_level();
        return (m_wcnt - ungray(m_hist[SS-1])) & 15;
    endfunction

    task automatic model_reset();
        m_wcnt = 0;
        m_full = 1'b0;
        m_ovf  = 1'b0;
        for (int i = 0; i < SS; i++) m_hist[i] = 0;
    endtask

    task automatic check_state(input string where);
        check({where, ".bptr"},  32'(B_WPTR),   32'(m_wcnt & 7));
        check({where, ".gptr"},  32'(G_WPTR),   32'(gray(m_wcnt & 15)));
        check({where, ".full"},  32'(FULL),     32'(m_full));
        check({where, ".ovf"},   32'(OVERFLOW), 32'(m_ovf));
        check({where, ".level"}, 32'(W_LEVEL),  32'(m_level()));
`ifdef FIFO_ALMOST_FULL_EN
        check({where, ".afull"}, 32'(ALMOST_FULL), 32'(m_level() >= AFL));
`endif
    endtask

    // One W_CLK cycle: drive at negedge, check accept, clock, update model, check state
    task automatic step(input logic en, input int rc, input string where);
        int  rgs_old;
        int  wnext;
        logic acc;
        @(negedge W_CLK);
        W_EN         = en;
        R_GPTR_ASYNC = 4'(gray(rc & 15));
        #1;
        acc = en && !m_full;
        check({where, ".accept"}, 32'(W_ACCEPT), 32'(acc));
        @(posedge W_CLK);
        rgs_old = m_hist[SS-1];
        wnext   = m_wcnt + int'(acc);
        if (en && m_full) m_ovf = 1'b1;
        m_full  = (((wnext - ungray(rgs_old)) & 15) == 8);
        m_wcnt  = wnext;
        for (int i = SS - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
        m_hist[0] = int'(R_GPTR_ASYNC);
        #1;
        check_state(where);
    endtask

    // Asynchronous reset asserted mid-cycle and checked before any clock edge
    task automatic do_reset(input string where);
        @(negedge W_CLK);
        #2;
        W_RST = 1'b1;
        W_EN  = 1'b0;
        R_GPTR_ASYNC = '0;
        m_rcnt = 0;
        model_reset();
        #1;
        check({where, ".rst_bptr"},  32'(B_WPTR),   32'd0);
        check({where, ".rst_gptr"},  32'(G_WPTR),   32'd0);
        check({where, ".rst_full"},  32'(FULL),     32'd0);
        check({where, ".rst_ovf"},   32'(OVERFLOW), 32'd0);
        check({where, ".rst_level"}, 32'(W_LEVEL),  32'd0);
        check({where, ".rst_acc"},   32'(W_ACCEPT), 32'd0);
        @(negedge W_CLK);
        W_RST = 1'b0;
    endtask

    initial begin
        W_RST = 1'b1;
        W_EN  = 1'b0;
        R_GPTR_ASYNC = '0;
        m_rcnt = 0;
        model_reset();
        #12;
        check("init.bptr", 32'(B_WPTR), 32'd0);
        check("init.full", 32'(FULL),   32'd0);
        @(negedge W_CLK);
        W_RST = 1'b0;

        // Reset mid-stream after five writes
        for (int i = 0; i < 5; i++) step(1'b1, 0, "t1.fill");
        check("t1.bptr5", 32'(B_WPTR), 32'd5);
        do_reset("t1");

        // Fill to full with the reader parked at zero
        for (int i = 0; i < 8; i++) step(1'b1, 0, "t2.fill");
        check("t2.full",  32'(FULL),    32'd1);
        check("t2.gptr",  32'(G_WPTR),  32'b1100);
        check("t2.level", 32'(W_LEVEL), 32'd8);

        // Writes while full are dropped and flagged
        for (int i = 0; i < 3; i++) step(1'b1, 0, "t3.over");
        check("t3.ovf",   32'(OVERFLOW), 32'd1);
        check("t3.bptr",  32'(B_WPTR),   32'd0);
        check("t3.gptr",  32'(G_WPTR),   32'b1100);

        // Read pointer advances to 3; FULL clears on the third edge
        step(1'b0, 3, "t4.sync");
        step(1'b0, 3, "t4.sync");
        check("t4.level5", 32'(W_LEVEL), 32'd5);
        check("t4.still_full", 32'(FULL), 32'd1);
        step(1'b0, 3, "t4.sync");
        check("t4.full_clr", 32'(FULL), 32'd0);
        check("t4.bptr0",    32'(B_WPTR), 32'd0);
        step(1'b1, 3, "t4.write");
        check("t4.bptr1",    32'(B_WPTR), 32'd1);
        check("t4.ovf_kept", 32'(OVERFLOW), 32'd1);
        do_reset("t4");

        // Sixteen writes with the reader two behind: pointer laps twice
        for (int i = 0; i < 16; i++) begin
            m_rcnt = (m_wcnt >= 2) ? m_wcnt - 2 : 0;
            step(1'b1, m_rcnt, "t5.wrap");
            check("t5.never_full", 32'(FULL), 32'd0);
        end
        check("t5.gptr0", 32'(G_WPTR), 32'd0);
        check("t5.bptr0", 32'(B_WPTR), 32'd0);

`ifdef FIFO_ALMOST_FULL_EN
        // Almost-full threshold with no reads
        do_reset("t6");
        for (int i = 0; i < 5; i++) step(1'b1, 0, "t6.fill");
        check("t6.af_at5", 32'(ALMOST_FULL), 32'd0);
        step(1'b1, 0, "t6.fill");
        check("t6.af_at6",   32'(ALMOST_FULL), 32'd1);
        check("t6.full_at6", 32'(FULL), 32'd0);
`endif

        // Randomized traffic with a legal, lagging reader
        do_reset("rnd");
        for (int i = 0; i < 400; i++) begin
            logic en;
            en = ($urandom_range(0, 3) != 0);
            if ((i / 50) % 2 == 0) begin
                if ($urandom_range(0, 2) == 0 && m_rcnt < m_wcnt) m_rcnt++;
            end else begin
                if ($urandom_range(0, 1) == 0 && m_rcnt < m_wcnt) m_rcnt++;
            end
            step(en, m_rcnt, "rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
